magic_pkt_tx: RTL and testbench
===============================

Name: magic_pkt_tx

Overview:
- Transmit-side Wake-on-LAN magic packet generator for the TSE MAC. It is the counterpart of the receive-path magic packet detector.
- On a host request it streams a complete Ethernet frame, FCS excluded, into the MAC transmit byte interface. The MAC appends preamble, SFD and FCS.
- Frame layout: DA, SA, EtherType, 6 sync bytes of 0xFF, then REPEAT copies of the 48-bit target MAC, MSB byte first.

Parameters:
- ETHERTYPE, 16'h0842, EtherType field value.
- REPEAT, 16, number of target-MAC copies (legal range 1..31).
- SYNC_LEN, 6, number of 0xFF sync bytes (legal range 1..7).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  request pulse; sampled only in IDLE
- dest_mac  in  48  destination address; latched on an accepted start
- src_mac  in  48  source address; latched on an accepted start
- target_mac  in  48  MAC to wake; latched on an accepted start
- abort  in  1  terminate the frame in progress
- tx_ready  in  1  MAC accepts the current byte
- tx_data  out  8  frame byte
- tx_valid  out  1  tx_data is valid
- tx_sof  out  1  first byte of the frame
- tx_eof  out  1  last byte of the frame
- tx_err  out  1  frame aborted; qualifies tx_eof
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after a frame completes or aborts

Behaviour:
- Reset: all outputs are 0 and the FSM goes to IDLE. This is a synchronous reset, so it takes effect only on a clk edge and overrides everything in that cycle, including an in-progress frame. Nothing is flushed; tx_valid drops the cycle after rst.
- Bytes:
  - A byte is transferred on any cycle where tx_valid & tx_ready.
  - While tx_valid & !tx_ready, tx_data, tx_sof, tx_eof and tx_err must hold stable.
- FSM states: IDLE, ADDR, TYPE, SYNC, BODY, PASS (feature only), LAST, DONE.
- IDLE:
  - start=1 latches the three MAC inputs and moves to ADDR.
  - On the next cycle tx_valid=1, tx_sof=1, tx_data=dest_mac[47:40].
  - busy=1 from that cycle until DONE is exited.
- ADDR: 12 bytes, dest_mac[47:40]..dest_mac[7:0] then src_mac[47:40]..src_mac[7:0]. Advances on each transfer.
- TYPE: ETHERTYPE[15:8], then ETHERTYPE[7:0].
- SYNC: SYNC_LEN bytes of 8'hFF.
- BODY:
  - A 3-bit byte index (0..5) and a 5-bit repeat counter (0..REPEAT-1).
  - Output byte = target_mac[47-8*idx -: 8].
  - idx wraps from 5 to 0 and increments the repeat counter.
  - The final byte (idx=5, rep=REPEAT-1) carries tx_eof=1 and leads to LAST.
- LAST:
  - The eof byte is held until transferred.
  - On transfer: tx_valid=0 next cycle, state DONE.
- DONE: done=1 for exactly one cycle, busy=0 at exit, return to IDLE.
- Total length without the feature: 14 + SYNC_LEN + 6*REPEAT bytes (116 at defaults).
- Byte counter: 8-bit frame byte counter, never wraps within legal parameters. The frame is never shorter than 60 bytes at defaults, so there is no padding logic. Padding is the MAC's job if parameters are reduced.
- start: ignored while busy=1, including during DONE. Only a start sampled in IDLE begins a frame.
- abort:
  - Sampled when busy and not in DONE.
  - If a byte is currently presented it completes with tx_eof=1 and tx_err=1. If that byte is accepted on the same cycle as abort, the next cycle presents a single byte 8'h00 with eof and err.
  - Then DONE with done=1.
  - abort in IDLE is ignored.
- Simultaneous rst with start or abort: rst wins.
- A tx_ready pulse while tx_valid=0 has no effect.
- tx_sof is asserted only on byte 0. tx_eof is asserted only on the last byte. Both are never asserted outside tx_valid.

Optional Feature:
- Macro: MAGIC_PKT_SECUREON_EN.
- When defined:
  - Adds input secureon_pw[47:0], latched on an accepted start.
  - Adds input secureon_en, also latched on an accepted start.
  - If secureon_en is latched 1, BODY is followed by PASS: 6 bytes secureon_pw[47:40]..[7:0], with tx_eof on the last PASS byte instead of the last BODY byte.
  - Frame length becomes 122 at defaults.
- When undefined: the ports, the PASS state and its logic are absent. Behaviour is identical to secureon_en=0.

Test Plan:
- Defaults, tx_ready tied 1, start with dest=FF..FF, src=00_11_22_33_44_55, target=AA_BB_CC_DD_EE_01:
  - 116 bytes on consecutive cycles.
  - Byte 0 = FF with sof.
  - Bytes 6..11 = 00,11,22,33,44,55.
  - Bytes 12,13 = 08,42.
  - Bytes 14..19 = FF.
  - Byte 20 = AA; byte 25 = 01.
  - Byte 115 = 01 with eof.
  - done pulses 1 cycle after.
- Same frame with tx_ready toggling pseudo-randomly:
  - Identical 116-byte sequence.
  - Outputs stable on every stalled cycle.
  - Cycle count = 116 + number of stall cycles.
- start re-pulsed at bytes 3 and 115 and in the DONE cycle:
  - Ignored; exactly one frame emitted.
  - A new start in IDLE produces a second frame.
- abort at byte 40 with tx_ready=0:
  - Byte 40 held, then transferred with eof=1, err=1.
  - done pulses; busy falls; no further tx_valid.
- rst asserted at byte 50:
  - Next cycle all outputs 0, IDLE.
  - A subsequent start produces a clean 116-byte frame with sof.
- With MAGIC_PKT_SECUREON_EN, secureon_en=1, pw=01_02_03_04_05_06:
  - 122 bytes; bytes 116..121 = 01..06, eof on byte 121.
  - With secureon_en=0: 116 bytes, eof on byte 115.

Source files
------------

// File: rtl/magic_pkt_tx.sv
// Wake-on-LAN magic packet transmitter feeding the MAC TX byte stream.
// Optional SecureOn password trailer: define MAGIC_PKT_SECUREON_EN.
module magic_pkt_tx #(
    parameter logic [15:0] ETHERTYPE = 16'h0842,
    parameter int          REPEAT    = 16,
    parameter int          SYNC_LEN  = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [47:0] dest_mac,
    input  logic [47:0] src_mac,
    input  logic [47:0] target_mac,
`ifdef MAGIC_PKT_SECUREON_EN
    input  logic [47:0] secureon_pw,
    input  logic        secureon_en,
`endif
    input  logic        abort,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        tx_err,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        TYPE,
        SYNC,
        BODY,
`ifdef MAGIC_PKT_SECUREON_EN
        PASS,
`endif
        LAST,
        DONE
    } state_t;

    localparam logic [4:0] REP_LAST = 5'(REPEAT - 1);
    localparam logic [7:0] SYNC_END = 8'(14 + SYNC_LEN);

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  idx;
    logic [4:0]  rep;
    logic [47:0] dst_q;
    logic [47:0] src_q;
    logic [47:0] tgt_q;

    logic [7:0]  nxt;
    logic [2:0]  ni;
    logic [4:0]  nr;

`ifdef MAGIC_PKT_SECUREON_EN
    logic        sec_on;
    logic [47:0] pw_q;
    logic        body_end;
`else
    localparam logic sec_on = 1'b0;
`endif

    function automatic logic [7:0] sel6(input logic [47:0] m,
                                        input logic [2:0]  i);
        case (i)
            3'd0:    return m[47:40];
            3'd1:    return m[39:32];
            3'd2:    return m[31:24];
            3'd3:    return m[23:16];
            3'd4:    return m[15:8];
            default: return m[7:0];
        endcase
    endfunction

    function automatic logic [7:0] hdr(input logic [7:0]  n,
                                       input logic [47:0] d,
                                       input logic [47:0] s);
        if (n < 8'd6)   return sel6(d, n[2:0]);
        if (n < 8'd12)  return sel6(s, 3'(n - 8'd6));
        if (n == 8'd12) return ETHERTYPE[15:8];
        if (n == 8'd13) return ETHERTYPE[7:0];
        return 8'hFF;
    endfunction

    always_comb begin
        nxt = cnt + 8'd1;
        ni  = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        nr  = (idx == 3'd5) ? rep + 5'd1 : rep;
`ifdef MAGIC_PKT_SECUREON_EN
        body_end = (idx == 3'd5) && (rep == REP_LAST);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            rep      <= '0;
            dst_q    <= '0;
            src_q    <= '0;
            tgt_q    <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            tx_sof   <= 1'b0;
            tx_eof   <= 1'b0;
            tx_err   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef MAGIC_PKT_SECUREON_EN
            sec_on   <= 1'b0;
            pw_q     <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dst_q    <= dest_mac;
                        src_q    <= src_mac;
                        tgt_q    <= target_mac;
`ifdef MAGIC_PKT_SECUREON_EN
                        pw_q     <= secureon_pw;
                        sec_on   <= secureon_en;
`endif
                        cnt      <= '0;
                        idx      <= '0;
                        rep      <= '0;
                        tx_data  <= dest_mac[47:40];
                        tx_valid <= 1'b1;
                        tx_sof   <= 1'b1;
                        tx_eof   <= 1'b0;
                        tx_err   <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ADDR;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    // abort tags the presented byte, or a 00 filler if it just left
                    if (abort && !tx_err) begin
                        tx_eof <= 1'b1;
                        tx_err <= 1'b1;
                        state  <= LAST;
                        if (tx_ready) begin
                            tx_data <= 8'h00;
                            tx_sof  <= 1'b0;
                        end
                    end else if (tx_ready) begin
                        tx_sof <= 1'b0;
                        cnt    <= nxt;
                        case (state)
                            ADDR: begin
                                tx_data <= hdr(nxt, dst_q, src_q);
                                if (nxt == 8'd12) state <= TYPE;
                            end
                            TYPE: begin
                                tx_data <= hdr(nxt, dst_q, src_q);
                                if (nxt == 8'd14) state <= SYNC;
                            end
                            SYNC: begin
                                if (nxt == SYNC_END) begin
                                    idx     <= '0;
                                    rep     <= '0;
                                    tx_data <= tgt_q[47:40];
                                    state   <= BODY;
                                end else begin
                                    tx_data <= 8'hFF;
                                end
                            end
                            BODY: begin
`ifdef MAGIC_PKT_SECUREON_EN
                                if (body_end) begin
                                    idx     <= '0;
                                    tx_data <= pw_q[47:40];
                                    state   <= PASS;
                                end else
`endif
                                begin
                                    idx     <= ni;
                                    rep     <= nr;
                                    tx_data <= sel6(tgt_q, ni);
                                    if (ni == 3'd5 && nr == REP_LAST
                                        && !sec_on) begin
                                        tx_eof <= 1'b1;
                                        state  <= LAST;
                                    end
                                end
                            end
`ifdef MAGIC_PKT_SECUREON_EN
                            PASS: begin
                                idx     <= ni;
                                tx_data <= sel6(pw_q, ni);
                                if (ni == 3'd5) begin
                                    tx_eof <= 1'b1;
                                    state  <= LAST;
                                end
                            end
`endif
                            LAST: begin
                                tx_valid <= 1'b0;
                                tx_data  <= '0;
                                tx_eof   <= 1'b0;
                                tx_err   <= 1'b0;
                                done     <= 1'b1;
                                state    <= DONE;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_magic_pkt_tx.sv
// Directed bench for magic_pkt_tx: nominal, stalled, restart, abort, reset.
// SecureOn trailer frame is exercised when MAGIC_PKT_SECUREON_EN is defined.
module tb_magic_pkt_tx;

    localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC = 48'h0011_2233_4455;
    localparam logic [47:0] TGT = 48'hAABB_CCDD_EE01;
    localparam logic [47:0] PW  = 48'h0102_0304_0506;

    logic        clk = 1'b0;
    logic        rst, start, abort, tx_ready;
    logic [47:0] dest_mac, src_mac, target_mac;
    logic [47:0] secureon_pw;
    logic        secureon_en;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_sof, tx_eof, tx_err, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] cap_d [0:127];
    logic       cap_s [0:127];
    logic       cap_e [0:127];
    logic       cap_r [0:127];
    int         nbytes_g, ncyc_g, nst_g, unst_g, lead_g;
    logic       to_g, end_done_g, end_busy_g;

    magic_pkt_tx dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dest_mac   (dest_mac),
        .src_mac    (src_mac),
        .target_mac (target_mac),
`ifdef MAGIC_PKT_SECUREON_EN
        .secureon_pw(secureon_pw),
        .secureon_en(secureon_en),
`endif
        .abort      (abort),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_sof     (tx_sof),
        .tx_eof     (tx_eof),
        .tx_err     (tx_err),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        logic [47:0] m;
        int k;
        if (i < 6) begin
            m = DST; k = i;
        end else if (i < 12) begin
            m = SRC; k = i - 6;
        end else if (i == 12) begin
            return 8'h08;
        end else if (i == 13) begin
            return 8'h42;
        end else if (i < 20) begin
            return 8'hFF;
        end else if (i < 116) begin
            m = TGT; k = (i - 20) % 6;
        end else begin
            m = PW; k = i - 116;
        end
        return m[47-8*k -: 8];
    endfunction

    task automatic step();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        dest_mac   = DST;
        src_mac    = SRC;
        target_mac = TGT;
        tx_ready   = 1'b1;
        start      = 1'b1;
    endtask

    task automatic collect(input bit rnd, input bit poke);
        logic [11:0] hv;
        bit held, fin;
        held = 0; fin = 0; hv = '0;
        nbytes_g = 0; ncyc_g = 0; nst_g = 0; unst_g = 0; lead_g = 0;
        end_done_g = 1'b0; end_busy_g = 1'b0;
        for (int c = 0; c < 800; c++) begin
            step();
            if (held && {tx_valid, tx_data, tx_sof, tx_eof, tx_err} !== hv)
                unst_g++;
            held = 0;
            if (!tx_valid) begin
                if (nbytes_g > 0) begin
                    end_done_g = done;
                    end_busy_g = busy;
                    if (poke) start = 1'b1;
                    fin = 1;
                    break;
                end
                lead_g++;
                continue;
            end
            ncyc_g++;
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_ready) begin
                if (nbytes_g < 128) begin
                    cap_d[nbytes_g] = tx_data;
                    cap_s[nbytes_g] = tx_sof;
                    cap_e[nbytes_g] = tx_eof;
                    cap_r[nbytes_g] = tx_err;
                end
                if (poke && (nbytes_g == 3 || nbytes_g == 115)) start = 1'b1;
                nbytes_g++;
            end else begin
                nst_g++;
                held = 1;
                hv = {tx_valid, tx_data, tx_sof, tx_eof, tx_err};
            end
        end
        to_g = !fin;
        tx_ready = 1'b1;
    endtask

    task automatic verify(input string tg, input int len);
        int bad, ns, ne, nr;
        bad = 0; ns = 0; ne = 0; nr = 0;
        check({tg, "_timeout"}, 32'(to_g), 0);
        check({tg, "_len"}, nbytes_g, len);
        for (int i = 0; i < nbytes_g && i < 128; i++) begin
            if (cap_d[i] !== exp_byte(i)) bad++;
            ns += int'(cap_s[i]);
            ne += int'(cap_e[i]);
            nr += int'(cap_r[i]);
        end
        check({tg, "_data_bad"}, bad, 0);
        check({tg, "_sof_cnt"}, ns, 1);
        check({tg, "_sof0"}, 32'(cap_s[0]), 1);
        check({tg, "_eof_cnt"}, ne, 1);
        if (nbytes_g >= len)
            check({tg, "_eof_last"}, 32'(cap_e[len-1]), 1);
        check({tg, "_err_cnt"}, nr, 0);
        check({tg, "_b0"}, cap_d[0], 8'hFF);
        check({tg, "_b6"}, cap_d[6], 8'h00);
        check({tg, "_b11"}, cap_d[11], 8'h55);
        check({tg, "_b12"}, cap_d[12], 8'h08);
        check({tg, "_b13"}, cap_d[13], 8'h42);
        check({tg, "_b19"}, cap_d[19], 8'hFF);
        check({tg, "_b20"}, cap_d[20], 8'hAA);
        check({tg, "_b25"}, cap_d[25], 8'h01);
        check({tg, "_b115"}, cap_d[115], 8'h01);
        check({tg, "_done_pulse"}, 32'(end_done_g), 1);
        check({tg, "_busy_in_done"}, 32'(end_busy_g), 1);
        step();
        check({tg, "_done_low"}, 32'(done), 0);
        check({tg, "_busy_low"}, 32'(busy), 0);
    endtask

    task automatic check_zero(input string tg);
        check({tg, "_valid"}, 32'(tx_valid), 0);
        check({tg, "_data"}, tx_data, 0);
        check({tg, "_sof"}, 32'(tx_sof), 0);
        check({tg, "_eof"}, 32'(tx_eof), 0);
        check({tg, "_err"}, 32'(tx_err), 0);
        check({tg, "_busy"}, 32'(busy), 0);
        check({tg, "_done"}, 32'(done), 0);
    endtask

    initial begin
        int k, quiet;
        bit found;
        rst = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
        dest_mac = '0; src_mac = '0; target_mac = '0;
        secureon_pw = PW; secureon_en = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst = 1'b0;

        // idle: abort and ready pulses do nothing
        abort = 1'b1; tx_ready = 1'b1;
        step(); step();
        abort = 1'b0;
        check("idle_abort_valid", 32'(tx_valid), 0);
        check("idle_abort_busy", 32'(busy), 0);

        do_start();
        collect(0, 0);
        check("nom_lead", lead_g, 0);
        check("nom_cycles", ncyc_g, 116);
        verify("nom", 116);

        do_start();
        collect(1, 0);
        check("rnd_stable", unst_g, 0);
        check("rnd_cycles", ncyc_g, 116 + nst_g);
        verify("rnd", 116);

        do_start();
        collect(0, 1);
        verify("poke", 116);
        quiet = 0;
        repeat (5) begin
            step();
            if (tx_valid || busy) quiet++;
        end
        check("poke_one_frame", quiet, 0);
        do_start();
        collect(0, 0);
        verify("second", 116);

        // abort while byte 40 is stalled
        do_start();
        k = 0; found = 0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (tx_valid) begin
                if (k == 40) begin
                    tx_ready = 1'b0; abort = 1'b1; found = 1;
                    break;
                end
                k++;
            end
        end
        check("ab_reach", 32'(found), 1);
        step();
        abort = 1'b0;
        check("ab_valid", 32'(tx_valid), 1);
        check("ab_data", tx_data, 8'hCC);
        check("ab_eof", 32'(tx_eof), 1);
        check("ab_err", 32'(tx_err), 1);
        step();
        check("ab_hold_data", tx_data, 8'hCC);
        check("ab_hold_eof", 32'(tx_eof), 1);
        tx_ready = 1'b1;
        step();
        check("ab_novalid", 32'(tx_valid), 0);
        check("ab_done", 32'(done), 1);
        step();
        check("ab_done_low", 32'(done), 0);
        check("ab_busy_low", 32'(busy), 0);
        quiet = 0;
        repeat (4) begin
            step();
            if (tx_valid) quiet++;
        end
        check("ab_quiet", quiet, 0);

        // reset mid-frame at byte 50
        do_start();
        k = 0; found = 0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (tx_valid) begin
                if (k == 50) begin
                    rst = 1'b1; found = 1;
                    break;
                end
                k++;
            end
        end
        check("mr_reach", 32'(found), 1);
        step();
        rst = 1'b0;
        check_zero("mr");
        do_start();
        collect(0, 0);
        verify("after_rst", 116);

`ifdef MAGIC_PKT_SECUREON_EN
        secureon_en = 1'b1;
        do_start();
        collect(0, 0);
        verify("sec", 122);
        check("sec_b116", cap_d[116], 8'h01);
        check("sec_b121", cap_d[121], 8'h06);
        check("sec_b115_noeof", 32'(cap_e[115]), 0);
        secureon_en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
